// File: rtl/spi_reg_bank_pkg.sv
// Shared definitions for the SPI register bank: control-word field positions,
// CPU select encodings and the status word layout.
package spi_reg_bank_pkg;

  // Control word fields
  localparam int CTRL_SEND     = 0;
  localparam int CTRL_CS       = 1;
  localparam int CTRL_ALL1     = 2;
  localparam int CTRL_ALL0     = 3;
  localparam int CTRL_NTX_LSB  = 4;
  localparam int CTRL_NTX_W    = 9;
  localparam int CTRL_NRX_LSB  = 16;
  localparam int CTRL_NRX_W    = 10;

  // CPU register select
  typedef enum logic [1:0] {
    SEL_CTRL = 2'b00,
    SEL_DATA = 2'b01,
    SEL_STAT = 2'b10,
    SEL_RSVD = 2'b11
  } cpu_sel_e;

  // Status word layout
  localparam int STAT_BUSY   = 31;
  localparam int STAT_OVF    = 30;
  localparam int STAT_DONE   = 29;
  localparam int STAT_WP_LSB = 8;
  localparam int STAT_RP_LSB = 0;
  localparam int STAT_PTR_W  = 8;

  function automatic logic [31:0] pack_status(input logic busy, input logic ovf,
                                              input logic done,
                                              input logic [STAT_PTR_W-1:0] wp,
                                              input logic [STAT_PTR_W-1:0] rp);
    logic [31:0] s;
    s = '0;
    s[STAT_BUSY] = busy;
    s[STAT_OVF]  = ovf;
    s[STAT_DONE] = done;
    s[STAT_WP_LSB +: STAT_PTR_W] = wp;
    s[STAT_RP_LSB +: STAT_PTR_W] = rp;
    return s;
  endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// CPU bus and SPI-master write-back bus of the register bank.
// irq_o exists only when SPI_IRQ_EN is defined.
interface spi_reg_bank_if #(parameter int ADDR_W = 6, parameter int DATA_W = 32);
  logic [1:0]        cpu_sel_i;
  logic              cpu_wr_i;
  logic              cpu_rd_i;
  logic [DATA_W-1:0] cpu_wdata_i;
  logic              cpu_ready_o;
  logic [DATA_W-1:0] cpu_rdata_o;
  logic              cpu_rvalid_o;
  logic              wr2_ctrl_i;
  logic              wr2_data_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] ctrl_wb_i;
  logic [DATA_W-1:0] data_wb_i;
  logic [DATA_W-1:0] reg_ctrl_o;
  logic [DATA_W-1:0] reg_data_o;
`ifdef SPI_IRQ_EN
  logic              irq_o;
`endif

  // Register bank side
  modport slave (
    input  cpu_sel_i, cpu_wr_i, cpu_rd_i, cpu_wdata_i,
    input  wr2_ctrl_i, wr2_data_i, addr_i, ctrl_wb_i, data_wb_i,
    output cpu_ready_o, cpu_rdata_o, cpu_rvalid_o, reg_ctrl_o, reg_data_o
`ifdef SPI_IRQ_EN
    , output irq_o
`endif
  );

  // CPU / SPI master side
  modport master (
    output cpu_sel_i, cpu_wr_i, cpu_rd_i, cpu_wdata_i,
    output wr2_ctrl_i, wr2_data_i, addr_i, ctrl_wb_i, data_wb_i,
    input  cpu_ready_o, cpu_rdata_o, cpu_rvalid_o, reg_ctrl_o, reg_data_o
`ifdef SPI_IRQ_EN
    , input irq_o
`endif
  );
endinterface

// File: rtl/spi_reg_bank_mem.sv
// DEPTH x DATA_W buffer: one write port (master write-back has priority over
// the CPU), a synchronous read port for CPU reads and an asynchronous peek
// port feeding the SPI master.
module spi_reg_bank_mem #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              m_we,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0] peek_addr,
  output logic [DATA_W-1:0] peek_data
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Write port mux: master wins over CPU
  always_comb begin
    wr_en   = m_we | c_we;
    wr_addr = m_we ? m_addr : c_addr;
    wr_data = m_we ? m_data : c_data;
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // CPU read port, one cycle latency
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  assign peek_data = mem[peek_addr];

endmodule

// File: rtl/spi_reg_bank.sv
// CPU-side register bank in front of the SPI master. Holds the control word
// and the TX/RX buffer, hands the buffer to the master while send is set and
// absorbs the master's write-backs.
// Optional feature macro: SPI_IRQ_EN (adds irq_o and a sticky done flag in status[29]).
module spi_reg_bank
  import spi_reg_bank_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input logic           clk_i,
  input logic           rst_i,
  spi_reg_bank_if.slave bus
);
  logic [DATA_W-1:0] reg_ctrl;
  logic [DATA_W-1:0] ctrl_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              ovf;
  logic              busy;
  logic              ready;
  logic              done;
  cpu_sel_e          sel;
  cpu_sel_e          rsel_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem_q;
  logic              rvalid_q;
  logic              wr_acc;
  logic              rd_acc;
  logic              ctrl_wr;
  logic              data_wr;
  logic              data_rd;
  logic              stat_rd;
  logic              start;
  logic [DATA_W-1:0] status_word;

  assign busy  = reg_ctrl[CTRL_SEND];
  assign ready = ~busy;
  assign sel   = cpu_sel_e'(bus.cpu_sel_i);

  // Request acceptance; a simultaneous write drops the read.
  // Master strobes take priority over a CPU write to the same target.
  always_comb begin
    wr_acc  = bus.cpu_wr_i & ready;
    rd_acc  = bus.cpu_rd_i & ready & ~bus.cpu_wr_i;
    ctrl_wr = wr_acc & (sel == SEL_CTRL) & ~bus.wr2_ctrl_i;
    data_wr = wr_acc & (sel == SEL_DATA) & ~bus.wr2_data_i;
    data_rd = rd_acc & (sel == SEL_DATA);
    stat_rd = rd_acc & (sel == SEL_STAT);
    start   = ctrl_wr & bus.cpu_wdata_i[CTRL_SEND];
  end

  // Next control word: master write-back over CPU write
  always_comb begin
    ctrl_next = reg_ctrl;
    if (bus.wr2_ctrl_i)  ctrl_next = bus.ctrl_wb_i;
    else if (ctrl_wr)    ctrl_next = bus.cpu_wdata_i;
  end

  // Control word, buffer pointers and sticky overflow
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      reg_ctrl <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ovf      <= 1'b0;
    end else begin
      reg_ctrl <= ctrl_next;
      if (start) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        ovf    <= 1'b0;
      end else begin
        if (data_wr) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (wr_ptr == '1) ovf <= 1'b1;
        end
        if (data_rd) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

`ifdef SPI_IRQ_EN
  logic fall;
  logic irq_q;

  assign fall = reg_ctrl[CTRL_SEND] & ~ctrl_next[CTRL_SEND];

  // Done pulse and sticky done flag; a new completion wins over a clearing read
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      irq_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      irq_q <= fall;
      if (fall)         done <= 1'b1;
      else if (stat_rd) done <= 1'b0;
    end
  end

  assign bus.irq_o = irq_q;
`else
  assign done = 1'b0;
`endif

  assign status_word = DATA_W'(pack_status(busy, ovf, done,
                                           STAT_PTR_W'(wr_ptr), STAT_PTR_W'(rd_ptr)));

  // Read capture for control/status/reserved; data reads come from the memory port
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rvalid_q <= 1'b0;
      rsel_q   <= SEL_CTRL;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) begin
        rsel_q <= sel;
        case (sel)
          SEL_CTRL: rdata_q <= reg_ctrl;
          SEL_STAT: rdata_q <= status_word;
          default:  rdata_q <= '0;
        endcase
      end
    end
  end

  spi_reg_bank_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk       (clk_i),
    .m_we      (bus.wr2_data_i),
    .m_addr    (bus.addr_i),
    .m_data    (bus.data_wb_i),
    .c_we      (data_wr),
    .c_addr    (wr_ptr),
    .c_data    (bus.cpu_wdata_i),
    .rd_en     (data_rd),
    .rd_addr   (rd_ptr),
    .rd_data   (mem_q),
    .peek_addr (bus.addr_i),
    .peek_data (bus.reg_data_o)
  );

  assign bus.cpu_ready_o  = ready;
  assign bus.cpu_rvalid_o = rvalid_q;
  assign bus.cpu_rdata_o  = (rsel_q == SEL_DATA) ? mem_q : rdata_q;
  assign bus.reg_ctrl_o   = reg_ctrl;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank. The SPI master is emulated by driving
// the write-back strobes directly; expectations come from a behavioural model.
module tb_spi_reg_bank;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  spi_reg_bank_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  spi_reg_bank #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Behavioural model
  logic [31:0] m_mem [64];
  int          m_wp, m_rp;
  bit          m_ovf, m_done;
  logic [31:0] m_ctrl;

  function automatic logic [31:0] exp_status();
    int s;
    s = (int'(m_ovf) << 30) | (m_wp << 8) | m_rp;
`ifdef SPI_IRQ_EN
    s = s | (int'(m_done) << 29);
`endif
    return 32'(s);
  endfunction

  task automatic model_reset();
    m_ctrl = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_done = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input int sel, input logic [31:0] d);
    bus.cpu_sel_i = 2'(sel); bus.cpu_wdata_i = d; bus.cpu_wr_i = 1'b1;
    tick();
    bus.cpu_wr_i = 1'b0;
    if (sel == 0) begin
      m_ctrl = d;
      if (d[0]) begin m_wp = 0; m_rp = 0; m_ovf = 0; end
    end else if (sel == 1) begin
      m_mem[m_wp] = d;
      m_wp = (m_wp + 1) % 64;
      if (m_wp == 0) m_ovf = 1;
    end
  endtask

  task automatic cpu_read(input int sel, input string tag);
    logic [31:0] e;
    case (sel)
      0: e = m_ctrl;
      1: begin e = m_mem[m_rp]; m_rp = (m_rp + 1) % 64; end
      2: begin e = exp_status(); m_done = 0; end
      default: e = 0;
    endcase
    bus.cpu_sel_i = 2'(sel); bus.cpu_rd_i = 1'b1;
    tick();
    bus.cpu_rd_i = 1'b0;
    chk({tag, "_rvalid"}, 32'(bus.cpu_rvalid_o), 1);
    chk(tag, bus.cpu_rdata_o, e);
  endtask

  task automatic master_ctrl(input logic [31:0] v);
    bit fell;
    fell = m_ctrl[0] & ~v[0];
    bus.wr2_ctrl_i = 1'b1; bus.ctrl_wb_i = v;
    tick();
    bus.wr2_ctrl_i = 1'b0;
    m_ctrl = v;
    if (fell) m_done = 1;
    chk("reg_ctrl_wb", bus.reg_ctrl_o, v);
`ifdef SPI_IRQ_EN
    chk("irq_pulse", 32'(bus.irq_o), 32'(fell));
`endif
  endtask

  task automatic master_data(input int a, input logic [31:0] d);
    bus.wr2_data_i = 1'b1; bus.addr_i = 6'(a); bus.data_wb_i = d;
    tick();
    bus.wr2_data_i = 1'b0;
    m_mem[a] = d;
  endtask

  initial begin
    logic [31:0] rx, d;
    int a;
    bus.cpu_sel_i = 0; bus.cpu_wr_i = 0; bus.cpu_rd_i = 0; bus.cpu_wdata_i = 0;
    bus.wr2_ctrl_i = 0; bus.wr2_data_i = 0; bus.addr_i = 0;
    bus.ctrl_wb_i = 0; bus.data_wb_i = 0;
    model_reset();

    // Reset values
    tick(); tick();
    chk("rst_ctrl", bus.reg_ctrl_o, 0);
    chk("rst_ready", 32'(bus.cpu_ready_o), 1);
    chk("rst_rvalid", 32'(bus.cpu_rvalid_o), 0);
    chk("rst_rdata", bus.cpu_rdata_o, 0);
    rst = 1'b1;
    tick();
    cpu_read(2, "rst_status");

    // Load two TX words, then start a transfer
    cpu_write(1, 32'hAA);
    cpu_write(1, 32'h55);
    cpu_read(2, "stat_wp2");
    cpu_write(0, 32'h11);
    chk("ctrl_send", bus.reg_ctrl_o, 32'h11);
    chk("busy_ready", 32'(bus.cpu_ready_o), 0);
    bus.addr_i = 0; #1;
    chk("peek0", bus.reg_data_o, m_mem[0]);
    bus.addr_i = 1; #1;
    chk("peek1", bus.reg_data_o, m_mem[1]);

    // Emulated loopback: RX byte is the complement of the TX byte
    rx = {24'h0, ~m_mem[0][7:0]};
    master_data(0, rx);
    master_ctrl(32'h10);
    chk("done_ready", 32'(bus.cpu_ready_o), 1);
    chk("pre_rvalid", 32'(bus.cpu_rvalid_o), 0);
    cpu_read(1, "loop_rx");
    cpu_read(2, "stat_done");
    cpu_read(2, "stat_done_clr");

    // CPU write held across a busy period
    cpu_write(0, 32'h0000_0001);
    bus.addr_i = 0;
    bus.cpu_sel_i = 2'd1; bus.cpu_wdata_i = 32'h1234; bus.cpu_wr_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_ready", 32'(bus.cpu_ready_o), 0);
      chk("hold_mem", bus.reg_data_o, m_mem[0]);
    end
    master_ctrl(32'h0);
    chk("hold_mem_rel", bus.reg_data_o, m_mem[0]);
    tick();
    bus.cpu_wr_i = 1'b0;
    m_mem[m_wp] = 32'h1234; m_wp = (m_wp + 1) % 64;
`ifdef SPI_IRQ_EN
    chk("irq_single", 32'(bus.irq_o), 0);
`endif
    chk("hold_accept", bus.reg_data_o, 32'h1234);
    cpu_read(2, "stat_hold");

    // Fill all 64 entries plus one, checking wrap and overflow
    cpu_write(0, ($urandom() & 32'h03FF_1FFE) | 32'h1);
    master_ctrl($urandom() & 32'h03FF_1FFE);
    for (int i = 0; i < 65; i++) cpu_write(1, $urandom());
    cpu_read(2, "stat_ovf");
    for (int i = 0; i < 10; i++) cpu_read(1, "rand_rd");
    for (int i = 0; i < 8; i++) begin
      a = int'($urandom_range(63, 0));
      bus.addr_i = 6'(a); #1;
      chk("rand_peek", bus.reg_data_o, m_mem[a]);
    end
    cpu_read(0, "ctrl_rd");
    cpu_read(3, "rsvd_rd");
    cpu_write(2, $urandom());
    cpu_write(3, $urandom());
    cpu_read(2, "stat_ignored_wr");

    // Starting a transfer clears overflow and pointers
    cpu_write(0, 32'h1);
    master_ctrl(32'h0);
    cpu_read(2, "stat_ovf_clr");

    // Write and read in the same cycle: write wins, no rvalid
    d = $urandom();
    bus.cpu_sel_i = 2'd1; bus.cpu_wdata_i = d; bus.cpu_wr_i = 1'b1; bus.cpu_rd_i = 1'b1;
    tick();
    bus.cpu_wr_i = 1'b0; bus.cpu_rd_i = 1'b0;
    m_mem[m_wp] = d; m_wp = (m_wp + 1) % 64;
    chk("wr_rd_rvalid", 32'(bus.cpu_rvalid_o), 0);
    cpu_read(2, "stat_wr_rd");
    cpu_read(1, "wr_rd_data");

    // Asynchronous reset in the middle of a transfer
    cpu_write(0, 32'h0000_0031);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("arst_ctrl", bus.reg_ctrl_o, 0);
    chk("arst_ready", 32'(bus.cpu_ready_o), 1);
    chk("arst_rdata", bus.cpu_rdata_o, 0);
    chk("arst_rvalid", 32'(bus.cpu_rvalid_o), 0);
    #1 rst = 1'b1;
    tick();
    cpu_read(2, "arst_status");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
